// File: rtl/kmeans_centroid_update_k3_d3_pkg.sv
// Shared constants, state encoding and helpers for the k-means centroid-update stage.
// Optional feature macro used by the top level: KMEANS_CONVERGE_EN.
package kmeans_pkg;

    localparam int K     = 3;
    localparam int D     = 3;
    localparam int IDX_W = 2;
    localparam int NSLOT = K * D;

    localparam int DATA_W_DEF  = 16;
    localparam int COUNT_W_DEF = 16;
    localparam int ACC_W_DEF   = DATA_W_DEF + COUNT_W_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIV    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Map a flat division slot (k*D + d) to its cluster index k.
    function automatic logic [IDX_W-1:0] slot_cluster(input logic [3:0] slot);
        logic [3:0] k;
        k = slot / 4'd3;
        return k[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/kmeans_centroid_update_k3_d3_if.sv
// Labelled-point stream from the assignment stage into the centroid-update stage.
interface kmeans_centroid_update_k3_d3_if
    import kmeans_pkg::*;
#(
    parameter int input_data_width = DATA_W_DEF
);
    logic                        in_valid;
    logic [input_data_width-1:0] input_data0;
    logic [input_data_width-1:0] input_data1;
    logic [input_data_width-1:0] input_data2;
    logic [IDX_W-1:0]            selected_centroid;
    logic                        epoch_done;

    modport master (
        output in_valid, input_data0, input_data1, input_data2,
               selected_centroid, epoch_done
    );

    modport slave (
        input  in_valid, input_data0, input_data1, input_data2,
               selected_centroid, epoch_done
    );
endinterface

// File: rtl/kmeans_centroid_update_k3_d3_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle.
// start loads the operands; acc_width iterations follow, and done is high during the
// last one with quotient valid in that same cycle. A zero divisor yields quotient 0.
module kmeans_div_seq
    import kmeans_pkg::*;
#(
    parameter int acc_width   = ACC_W_DEF,
    parameter int count_width = COUNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [acc_width-1:0]   dividend,
    input  logic [count_width-1:0] divisor,
    output logic [acc_width-1:0]   quotient,
    output logic                   done
);
    localparam int AW    = acc_width;
    localparam int CW    = count_width;
    localparam int CNT_W = $clog2(AW + 1);

    logic [CW-1:0]    rem_q, rem_d;
    logic [AW-1:0]    quo_q, quo_d;
    logic [CW-1:0]    dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    logic [CW:0]      shifted;
    logic [CW-1:0]    diff;
    logic             ge;
    logic [AW-1:0]    quo_next;
    logic [CW-1:0]    rem_next;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[AW-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        diff     = shifted[CW-1:0] - dvs_q;
        rem_next = ge ? diff : shifted[CW-1:0];
        quo_next = {quo_q[AW-2:0], ge};
    end

    // Operand load on start, otherwise iterate while running.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_W'(AW);
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) run_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done     = run_q && (cnt_q == CNT_W'(1));
    assign quotient = (dvs_q == '0) ? '0 : quo_next;

endmodule

// File: rtl/kmeans_centroid_update_k3_d3.sv
// Centroid-update stage (K=3, D=3): accumulates labelled points over an epoch, divides
// each coordinate sum by its cluster count sequentially, then commits new centroids.
// Optional feature: define KMEANS_CONVERGE_EN to enable the converged flag.
module kmeans_centroid_update_k3_d3
    import kmeans_pkg::*;
#(
    parameter int input_data_width = DATA_W_DEF,
    parameter int count_width      = COUNT_W_DEF,
    parameter int acc_width        = input_data_width + count_width
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_centroids,
    input  logic [input_data_width-1:0] centroid_init0_d0,
    input  logic [input_data_width-1:0] centroid_init0_d1,
    input  logic [input_data_width-1:0] centroid_init0_d2,
    input  logic [input_data_width-1:0] centroid_init1_d0,
    input  logic [input_data_width-1:0] centroid_init1_d1,
    input  logic [input_data_width-1:0] centroid_init1_d2,
    input  logic [input_data_width-1:0] centroid_init2_d0,
    input  logic [input_data_width-1:0] centroid_init2_d1,
    input  logic [input_data_width-1:0] centroid_init2_d2,
    kmeans_centroid_update_k3_d3_if.slave pt,
    output logic [input_data_width-1:0] centroid0_d0,
    output logic [input_data_width-1:0] centroid0_d1,
    output logic [input_data_width-1:0] centroid0_d2,
    output logic [input_data_width-1:0] centroid1_d0,
    output logic [input_data_width-1:0] centroid1_d1,
    output logic [input_data_width-1:0] centroid1_d2,
    output logic [input_data_width-1:0] centroid2_d0,
    output logic [input_data_width-1:0] centroid2_d1,
    output logic [input_data_width-1:0] centroid2_d2,
    output logic                        busy,
    output logic                        update_done,
    output logic                        err,
    output logic                        converged
);
    localparam int IW = input_data_width;
    localparam int CW = count_width;
    localparam int AW = acc_width;
    localparam logic [3:0] LAST_SLOT = 4'(NSLOT - 1);

    state_t state_q, state_d;

    logic [NSLOT-1:0][AW-1:0] sum_q, sum_d;
    logic [K-1:0][CW-1:0]     cnt_q, cnt_d;
    logic [NSLOT-1:0][IW-1:0] cen_q, cen_d;
    logic [NSLOT-1:0][IW-1:0] new_q, new_d;
    logic [3:0]               slot_q, slot_d;
    logic                     pend_q, pend_d;
    logic                     err_q, err_d;

    logic [NSLOT-1:0][IW-1:0] init_v;
    logic [D-1:0][IW-1:0]     point_v;
    logic [IDX_W-1:0]         lbl_k;
    logic [IDX_W-1:0]         slot_k;
    logic                     accept_ok;
    logic                     div_start;
    logic                     div_done;
    logic [AW-1:0]            div_quo;
    logic                     unused_quo_hi;

    assign init_v = {centroid_init2_d2, centroid_init2_d1, centroid_init2_d0,
                     centroid_init1_d2, centroid_init1_d1, centroid_init1_d0,
                     centroid_init0_d2, centroid_init0_d1, centroid_init0_d0};
    assign point_v = {pt.input_data2, pt.input_data1, pt.input_data0};

    // Label 3 is never accepted; remapping only keeps the array index in range.
    assign lbl_k  = (pt.selected_centroid == 2'd3) ? '0 : pt.selected_centroid;
    assign slot_k = slot_cluster(slot_q);

    assign accept_ok = pt.in_valid && !busy && (pt.selected_centroid != 2'd3)
                       && (cnt_q[lbl_k] != '1);

    kmeans_div_seq #(
        .acc_width   (AW),
        .count_width (CW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_q[slot_q]),
        .divisor  (cnt_q[slot_k]),
        .quotient (div_quo),
        .done     (div_done)
    );

    // Quotients always fit in the coordinate width; the high bits are intentionally dropped.
    assign unused_quo_hi = ^div_quo[AW-1:IW];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!load_centroids) begin
                    if (pt.epoch_done)    state_d = DIV;
                    else if (pt.in_valid) state_d = ACCUM;
                end
            end
            ACCUM:   if (pt.epoch_done) state_d = DIV;
            DIV:     if (div_done && (slot_q == LAST_SLOT)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: status flags and divider slot launch.
    always_comb begin
        busy        = (state_q == DIV) || (state_q == COMMIT);
        update_done = (state_q == COMMIT);
        div_start   = (state_q == DIV) && pend_q;
    end

    // Accumulation, slot sequencing, quotient capture and commit.
    always_comb begin
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        cen_d  = cen_q;
        new_d  = new_q;
        err_d  = err_q;
        slot_d = slot_q;
        pend_d = pend_q;

        if ((state_q == IDLE) && load_centroids) begin
            cen_d = init_v;
            sum_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (accept_ok) begin
            for (int d = 0; d < D; d++) begin
                sum_d[lbl_k*D + d] = sum_q[lbl_k*D + d] + AW'(point_v[d]);
            end
            cnt_d[lbl_k] = cnt_q[lbl_k] + CW'(1);
        end else if (pt.in_valid) begin
            err_d = 1'b1;
        end

        if (state_q != DIV) begin
            slot_d = '0;
            pend_d = 1'b1;
        end else begin
            if (div_start) pend_d = 1'b0;
            if (div_done) begin
                // Empty cluster keeps its centroid; its slot still runs full length.
                new_d[slot_q] = (cnt_q[slot_k] == '0) ? cen_q[slot_q] : div_quo[IW-1:0];
                if (slot_q != LAST_SLOT) begin
                    slot_d = slot_q + 4'd1;
                    pend_d = 1'b1;
                end
            end
        end

        if (state_q == COMMIT) begin
            cen_d = new_q;
            sum_d = '0;
            cnt_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            cen_q  <= '0;
            new_q  <= '0;
            slot_q <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            cen_q  <= cen_d;
            new_q  <= new_d;
            slot_q <= slot_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

`ifdef KMEANS_CONVERGE_EN
    logic conv_q, conv_d;

    // Converged reflects whether the last commit changed any coordinate.
    always_comb begin
        conv_d = conv_q;
        if (state_q == COMMIT) conv_d = (new_q == cen_q);
    end

    // Converged flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conv_q <= 1'b0;
        else        conv_q <= conv_d;
    end

    assign converged = conv_q;
`else
    assign converged = 1'b0;
`endif

    assign err = err_q;

    assign centroid0_d0 = cen_q[0];
    assign centroid0_d1 = cen_q[1];
    assign centroid0_d2 = cen_q[2];
    assign centroid1_d0 = cen_q[3];
    assign centroid1_d1 = cen_q[4];
    assign centroid1_d2 = cen_q[5];
    assign centroid2_d0 = cen_q[6];
    assign centroid2_d1 = cen_q[7];
    assign centroid2_d2 = cen_q[8];

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d3.sv
// Directed bench for kmeans_centroid_update_k3_d3: table of epochs plus hand sequences.
module tb_kmeans_centroid_update_k3_d3;

    typedef logic [2:0][15:0]      pt3_t;
    typedef logic [2:0][2:0][15:0] cen_t;

    typedef struct {
        cen_t             init;
        int               npts;
        logic [3:0][2:0][15:0] pts;
        logic [3:0][1:0]  lbls;
        logic             ed_last;
        cen_t             exp_c;
        logic             exp_err;
    } vec_t;

    localparam int NV = 5;

`ifdef KMEANS_CONVERGE_EN
    localparam logic EXP_CONV2 = 1'b1;
`else
    localparam logic EXP_CONV2 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_centroids = 1'b0;
    cen_t init_c = '0;
    cen_t oc;
    logic busy, update_done, err, converged;

    int checks = 0;
    int failures = 0;

    kmeans_centroid_update_k3_d3_if #(.input_data_width(16)) sif ();

    kmeans_centroid_update_k3_d3 dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_centroids    (load_centroids),
        .centroid_init0_d0 (init_c[0][0]),
        .centroid_init0_d1 (init_c[0][1]),
        .centroid_init0_d2 (init_c[0][2]),
        .centroid_init1_d0 (init_c[1][0]),
        .centroid_init1_d1 (init_c[1][1]),
        .centroid_init1_d2 (init_c[1][2]),
        .centroid_init2_d0 (init_c[2][0]),
        .centroid_init2_d1 (init_c[2][1]),
        .centroid_init2_d2 (init_c[2][2]),
        .pt                (sif),
        .centroid0_d0      (oc[0][0]),
        .centroid0_d1      (oc[0][1]),
        .centroid0_d2      (oc[0][2]),
        .centroid1_d0      (oc[1][0]),
        .centroid1_d1      (oc[1][1]),
        .centroid1_d2      (oc[1][2]),
        .centroid2_d0      (oc[2][0]),
        .centroid2_d1      (oc[2][1]),
        .centroid2_d2      (oc[2][2]),
        .busy              (busy),
        .update_done       (update_done),
        .err               (err),
        .converged         (converged)
    );

    always #5 clk = ~clk;

    function automatic pt3_t p3(input int x, input int y, input int z);
        pt3_t r;
        r[0] = 16'(x);
        r[1] = 16'(y);
        r[2] = 16'(z);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_c(input cen_t c);
        init_c = c;
        load_centroids = 1'b1;
        tick();
        load_centroids = 1'b0;
    endtask

    task automatic send_point(input pt3_t p, input logic [1:0] lbl, input logic ed);
        sif.in_valid = 1'b1;
        sif.input_data0 = p[0];
        sif.input_data1 = p[1];
        sif.input_data2 = p[2];
        sif.selected_centroid = lbl;
        sif.epoch_done = ed;
        tick();
        sif.in_valid = 1'b0;
        sif.epoch_done = 1'b0;
    endtask

    task automatic pulse_epoch();
        sif.epoch_done = 1'b1;
        tick();
        sif.epoch_done = 1'b0;
    endtask

    // Entered in the first cycle after epoch_done was sampled; leaves one cycle after COMMIT.
    task automatic finish_epoch(input string tag, input bit inject);
        int cyc;
        cyc = 1;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        while (update_done !== 1'b1 && cyc < 400) begin
            if (inject && cyc == 10) begin
                sif.in_valid = 1'b1;
                sif.input_data0 = 16'd500;
                sif.input_data1 = 16'd500;
                sif.input_data2 = 16'd500;
                sif.selected_centroid = 2'd0;
            end
            tick();
            sif.in_valid = 1'b0;
            cyc++;
        end
        chk({tag, "_done_cycle"}, 64'(cyc), 64'd298);
        chk({tag, "_busy_commit"}, 64'(busy), 64'd1);
        tick();
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_done_pulse_end"}, 64'(update_done), 64'd0);
    endtask

    vec_t v [NV];

    initial begin
        int seen;

        for (int i = 0; i < NV; i++) begin
            v[i].init = '0; v[i].npts = 0; v[i].pts = '0; v[i].lbls = '0;
            v[i].ed_last = 1'b0; v[i].exp_c = '0; v[i].exp_err = 1'b0;
        end
        // basic two-point epoch on cluster 0
        v[0].npts = 2;
        v[0].pts[0] = p3(10, 20, 30); v[0].lbls[0] = 2'd0;
        v[0].pts[1] = p3(20, 40, 50); v[0].lbls[1] = 2'd0;
        v[0].exp_c[0] = p3(15, 30, 40);
        // truncation on cluster 1, empty clusters 0 and 2 keep their init values
        v[1].init[0] = p3(5, 5, 5); v[1].init[1] = p3(9, 9, 9); v[1].init[2] = p3(7, 8, 9);
        v[1].npts = 3;
        v[1].pts[0] = p3(1, 1, 1); v[1].lbls[0] = 2'd1;
        v[1].pts[1] = p3(2, 2, 2); v[1].lbls[1] = 2'd1;
        v[1].pts[2] = p3(2, 2, 2); v[1].lbls[2] = 2'd1;
        v[1].exp_c[0] = p3(5, 5, 5); v[1].exp_c[1] = p3(1, 1, 1); v[1].exp_c[2] = p3(7, 8, 9);
        // final point shares the cycle with epoch_done
        v[2].init[0] = p3(1, 2, 3); v[2].init[1] = p3(4, 4, 4); v[2].init[2] = p3(6, 6, 6);
        v[2].npts = 3; v[2].ed_last = 1'b1;
        v[2].pts[0] = p3(3, 3, 3);   v[2].lbls[0] = 2'd1;
        v[2].pts[1] = p3(8, 9, 10);  v[2].lbls[1] = 2'd2;
        v[2].pts[2] = p3(100, 0, 0); v[2].lbls[2] = 2'd0;
        v[2].exp_c[0] = p3(100, 0, 0); v[2].exp_c[1] = p3(3, 3, 3); v[2].exp_c[2] = p3(8, 9, 10);
        // label 3 is dropped and flags err
        v[3].npts = 3; v[3].exp_err = 1'b1;
        v[3].pts[0] = p3(50, 60, 70);    v[3].lbls[0] = 2'd2;
        v[3].pts[1] = p3(999, 999, 999); v[3].lbls[1] = 2'd3;
        v[3].pts[2] = p3(10, 20, 30);    v[3].lbls[2] = 2'd2;
        v[3].exp_c[2] = p3(30, 40, 50);
        // near-full-scale coordinates exercise the wide sums
        v[4].npts = 3;
        v[4].pts[0] = p3(65535, 65535, 65535); v[4].lbls[0] = 2'd0;
        v[4].pts[1] = p3(65535, 0, 1);         v[4].lbls[1] = 2'd0;
        v[4].pts[2] = p3(65534, 2, 3);         v[4].lbls[2] = 2'd0;
        v[4].exp_c[0] = p3(65534, 21845, 21846);

        sif.in_valid = 1'b0;
        sif.input_data0 = '0; sif.input_data1 = '0; sif.input_data2 = '0;
        sif.selected_centroid = '0;
        sif.epoch_done = 1'b0;

        repeat (3) tick();
        chk("rst_centroids", 64'(oc == '0), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_update_done", 64'(update_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_converged", 64'(converged), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            load_c(v[i].init);
            for (int p = 0; p < v[i].npts; p++) begin
                send_point(v[i].pts[p], v[i].lbls[p], v[i].ed_last && (p == v[i].npts - 1));
            end
            if (!v[i].ed_last) pulse_epoch();
            finish_epoch($sformatf("v%0d", i), 1'b0);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("v%0d_c%0d", i, k), 64'(oc[k]), 64'(v[i].exp_c[k]));
            end
            chk($sformatf("v%0d_err", i), 64'(err), 64'(v[i].exp_err));
            chk($sformatf("v%0d_conv", i), 64'(converged), 64'd0);
        end

        // point arriving during DIV is dropped
        load_c('0);
        send_point(p3(10, 20, 30), 2'd0, 1'b0);
        send_point(p3(20, 40, 50), 2'd0, 1'b0);
        pulse_epoch();
        finish_epoch("divdrop", 1'b1);
        chk("divdrop_c0", 64'(oc[0]), 64'(p3(15, 30, 40)));
        chk("divdrop_err", 64'(err), 64'd1);
        load_c('0);
        chk("load_clears_err", 64'(err), 64'd0);

        // identical epoch twice
        send_point(p3(4, 4, 4), 2'd0, 1'b0);
        pulse_epoch();
        finish_epoch("conv1", 1'b0);
        chk("conv1_c0", 64'(oc[0]), 64'(p3(4, 4, 4)));
        chk("conv1_flag", 64'(converged), 64'd0);
        send_point(p3(4, 4, 4), 2'd0, 1'b0);
        pulse_epoch();
        finish_epoch("conv2", 1'b0);
        chk("conv2_c0", 64'(oc[0]), 64'(p3(4, 4, 4)));
        chk("conv2_flag", 64'(converged), 64'(EXP_CONV2));

        // reset 50 cycles into DIV
        load_c({p3(0, 0, 0), p3(0, 0, 0), p3(11, 12, 13)});
        send_point(p3(20, 20, 20), 2'd0, 1'b0);
        pulse_epoch();
        repeat (50) tick();
        chk("middiv_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("middiv_centroids", 64'(oc == '0), 64'd1);
        chk("middiv_busy_rst", 64'(busy), 64'd0);
        chk("middiv_err", 64'(err), 64'd0);
        chk("middiv_converged", 64'(converged), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 310; c++) begin
            tick();
            if (update_done === 1'b1) seen++;
        end
        chk("middiv_no_done", 64'(seen), 64'd0);
        chk("middiv_centroids_after", 64'(oc == '0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
